// File: rtl/tile_nv_pingpong.sv
// Ping-pong L1 tile store for left/right Native Vectors. Dispatch fills the write
// bank line by line; compute reads whole NVs from the committed bank one cycle later.
module tile_nv_pingpong #(
  parameter int unsigned MAN_WIDTH       = 256,
  parameter int unsigned EXP_WIDTH       = 8,
  parameter int unsigned GROUPS          = 4,
  parameter int unsigned NV_DEPTH        = 128,
  parameter int unsigned NV_IDX_WIDTH    = $clog2(NV_DEPTH),
  parameter int unsigned LINE_ADDR_WIDTH = $clog2(NV_DEPTH*GROUPS)
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_man_left_wr_en,
  input  logic [LINE_ADDR_WIDTH-1:0]    i_man_left_wr_addr,
  input  logic [MAN_WIDTH-1:0]          i_man_left_wr_data,
  input  logic                          i_man_right_wr_en,
  input  logic [LINE_ADDR_WIDTH-1:0]    i_man_right_wr_addr,
  input  logic [MAN_WIDTH-1:0]          i_man_right_wr_data,
  input  logic                          i_exp_left_wr_en,
  input  logic [LINE_ADDR_WIDTH-1:0]    i_exp_left_wr_addr,
  input  logic [EXP_WIDTH-1:0]          i_exp_left_wr_data,
  input  logic                          i_exp_right_wr_en,
  input  logic [LINE_ADDR_WIDTH-1:0]    i_exp_right_wr_addr,
  input  logic [EXP_WIDTH-1:0]          i_exp_right_wr_data,
  input  logic                          i_wr_commit,
  output logic                          o_wr_ready,
  input  logic                          i_rd_en,
  input  logic [NV_IDX_WIDTH-1:0]       i_nv_left_rd_idx,
  input  logic [NV_IDX_WIDTH-1:0]       i_nv_right_rd_idx,
  output logic                          o_rd_valid,
  output logic [GROUPS*EXP_WIDTH-1:0]   o_nv_left_exp,
  output logic [GROUPS*EXP_WIDTH-1:0]   o_nv_right_exp,
  output logic [GROUPS*MAN_WIDTH-1:0]   o_nv_left_man,
  output logic [GROUPS*MAN_WIDTH-1:0]   o_nv_right_man,
  input  logic                          i_rd_release,
  output logic                          o_rd_bank_valid,
  output logic [2:0]                    o_err
);

  localparam int unsigned GRP_W = $clog2(GROUPS);

  typedef enum logic {BANK_EMPTY = 1'b0, BANK_FULL = 1'b1} bank_st_e;

  bank_st_e bank_st_q [2];
  bank_st_e bank_st_d [2];
  logic     wr_ptr_q, wr_ptr_d;
  logic     rd_ptr_q, rd_ptr_d;
  logic [2:0] err_q, err_d;
  logic     rd_valid_q;
  logic [GROUPS*EXP_WIDTH-1:0] exp_l_q, exp_r_q, exp_l_rd, exp_r_rd;
  logic [GROUPS*MAN_WIDTH-1:0] man_l_q, man_r_q, man_l_rd, man_r_rd;

  // Storage organised as [bank][nv][group] so a whole NV is one read
  logic [MAN_WIDTH-1:0] man_l_mem [2][NV_DEPTH][GROUPS];
  logic [MAN_WIDTH-1:0] man_r_mem [2][NV_DEPTH][GROUPS];
  logic [EXP_WIDTH-1:0] exp_l_mem [2][NV_DEPTH][GROUPS];
  logic [EXP_WIDTH-1:0] exp_r_mem [2][NV_DEPTH][GROUPS];

  logic wr_ready, rd_bank_valid;
  logic man_l_we, man_r_we, exp_l_we, exp_r_we;
  logic any_wr, commit_ok, rd_accept, release_ok;

  assign wr_ready      = (bank_st_q[wr_ptr_q] == BANK_EMPTY);
  assign rd_bank_valid = (bank_st_q[rd_ptr_q] == BANK_FULL);

  assign man_l_we   = i_man_left_wr_en  & wr_ready;
  assign man_r_we   = i_man_right_wr_en & wr_ready;
  assign exp_l_we   = i_exp_left_wr_en  & wr_ready;
  assign exp_r_we   = i_exp_right_wr_en & wr_ready;
  assign any_wr     = i_man_left_wr_en | i_man_right_wr_en |
                      i_exp_left_wr_en | i_exp_right_wr_en;
  assign commit_ok  = i_wr_commit  & wr_ready;
  assign rd_accept  = i_rd_en      & rd_bank_valid;
  assign release_ok = i_rd_release & rd_bank_valid;

  always_ff @(posedge i_clk) begin
    if (man_l_we)
      man_l_mem[wr_ptr_q][i_man_left_wr_addr[LINE_ADDR_WIDTH-1:GRP_W]]
               [i_man_left_wr_addr[GRP_W-1:0]] <= i_man_left_wr_data;
    if (man_r_we)
      man_r_mem[wr_ptr_q][i_man_right_wr_addr[LINE_ADDR_WIDTH-1:GRP_W]]
               [i_man_right_wr_addr[GRP_W-1:0]] <= i_man_right_wr_data;
    if (exp_l_we)
      exp_l_mem[wr_ptr_q][i_exp_left_wr_addr[LINE_ADDR_WIDTH-1:GRP_W]]
               [i_exp_left_wr_addr[GRP_W-1:0]] <= i_exp_left_wr_data;
    if (exp_r_we)
      exp_r_mem[wr_ptr_q][i_exp_right_wr_addr[LINE_ADDR_WIDTH-1:GRP_W]]
               [i_exp_right_wr_addr[GRP_W-1:0]] <= i_exp_right_wr_data;
  end

  always_comb begin
    man_l_rd = '0;
    man_r_rd = '0;
    exp_l_rd = '0;
    exp_r_rd = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      man_l_rd[g*MAN_WIDTH +: MAN_WIDTH] = man_l_mem[rd_ptr_q][i_nv_left_rd_idx][GRP_W'(g)];
      man_r_rd[g*MAN_WIDTH +: MAN_WIDTH] = man_r_mem[rd_ptr_q][i_nv_right_rd_idx][GRP_W'(g)];
      exp_l_rd[g*EXP_WIDTH +: EXP_WIDTH] = exp_l_mem[rd_ptr_q][i_nv_left_rd_idx][GRP_W'(g)];
      exp_r_rd[g*EXP_WIDTH +: EXP_WIDTH] = exp_r_mem[rd_ptr_q][i_nv_right_rd_idx][GRP_W'(g)];
    end
  end

  // Commit needs its bank EMPTY and release needs its bank FULL, so when both
  // fire they always touch different banks and the updates cannot collide.
  always_comb begin
    bank_st_d[0] = bank_st_q[0];
    bank_st_d[1] = bank_st_q[1];
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    err_d        = err_q;
    if (commit_ok) begin
      bank_st_d[wr_ptr_q] = BANK_FULL;
      wr_ptr_d            = ~wr_ptr_q;
    end
    if (release_ok) begin
      bank_st_d[rd_ptr_q] = BANK_EMPTY;
      rd_ptr_d            = ~rd_ptr_q;
    end
    if (any_wr && !wr_ready)                      err_d[0] = 1'b1;
    if (i_wr_commit && !wr_ready)                 err_d[1] = 1'b1;
    if ((i_rd_en || i_rd_release) && !rd_bank_valid) err_d[2] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      err_q        <= '0;
      rd_valid_q   <= 1'b0;
      exp_l_q      <= '0;
      exp_r_q      <= '0;
      man_l_q      <= '0;
      man_r_q      <= '0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
      rd_valid_q   <= rd_accept;
      if (rd_accept) begin
        exp_l_q <= exp_l_rd;
        exp_r_q <= exp_r_rd;
        man_l_q <= man_l_rd;
        man_r_q <= man_r_rd;
      end
    end
  end

  assign o_wr_ready      = wr_ready;
  assign o_rd_bank_valid = rd_bank_valid;
  assign o_rd_valid      = rd_valid_q;
  assign o_nv_left_exp   = exp_l_q;
  assign o_nv_right_exp  = exp_r_q;
  assign o_nv_left_man   = man_l_q;
  assign o_nv_right_man  = man_r_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_tile_nv_pingpong.sv
// Self-checking bench for tile_nv_pingpong: directed scenarios plus a randomized
// phase, all compared against a line-addressed bank model.
module tb_tile_nv_pingpong;
  localparam int MW  = 256;
  localparam int EW  = 8;
  localparam int GR  = 4;
  localparam int ND  = 128;
  localparam int NIW = 7;
  localparam int LAW = 9;

  logic clk, rst_n;
  logic           i_man_left_wr_en, i_man_right_wr_en, i_exp_left_wr_en, i_exp_right_wr_en;
  logic [LAW-1:0] i_man_left_wr_addr, i_man_right_wr_addr, i_exp_left_wr_addr, i_exp_right_wr_addr;
  logic [MW-1:0]  i_man_left_wr_data, i_man_right_wr_data;
  logic [EW-1:0]  i_exp_left_wr_data, i_exp_right_wr_data;
  logic           i_wr_commit, i_rd_en, i_rd_release;
  logic [NIW-1:0] i_nv_left_rd_idx, i_nv_right_rd_idx;
  logic           o_wr_ready, o_rd_valid, o_rd_bank_valid;
  logic [GR*EW-1:0] o_nv_left_exp, o_nv_right_exp;
  logic [GR*MW-1:0] o_nv_left_man, o_nv_right_man;
  logic [2:0]     o_err;

  tile_nv_pingpong #(.MAN_WIDTH(MW), .EXP_WIDTH(EW), .GROUPS(GR), .NV_DEPTH(ND)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_man_left_wr_en(i_man_left_wr_en), .i_man_left_wr_addr(i_man_left_wr_addr),
    .i_man_left_wr_data(i_man_left_wr_data),
    .i_man_right_wr_en(i_man_right_wr_en), .i_man_right_wr_addr(i_man_right_wr_addr),
    .i_man_right_wr_data(i_man_right_wr_data),
    .i_exp_left_wr_en(i_exp_left_wr_en), .i_exp_left_wr_addr(i_exp_left_wr_addr),
    .i_exp_left_wr_data(i_exp_left_wr_data),
    .i_exp_right_wr_en(i_exp_right_wr_en), .i_exp_right_wr_addr(i_exp_right_wr_addr),
    .i_exp_right_wr_data(i_exp_right_wr_data),
    .i_wr_commit(i_wr_commit), .o_wr_ready(o_wr_ready),
    .i_rd_en(i_rd_en), .i_nv_left_rd_idx(i_nv_left_rd_idx), .i_nv_right_rd_idx(i_nv_right_rd_idx),
    .o_rd_valid(o_rd_valid), .o_nv_left_exp(o_nv_left_exp), .o_nv_right_exp(o_nv_right_exp),
    .o_nv_left_man(o_nv_left_man), .o_nv_right_man(o_nv_right_man),
    .i_rd_release(i_rd_release), .o_rd_bank_valid(o_rd_bank_valid), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: [side][bank][flat line address]; side 0 = left
  logic [MW-1:0] m_man [2][2][ND*GR];
  logic [EW-1:0] m_exp [2][2][ND*GR];
  logic [1:0]    m_full;
  int            m_wp, m_rp;
  logic          m_valid;
  logic [2:0]    m_err;
  logic [GR*EW-1:0] m_lexp, m_rexp;
  logic [GR*MW-1:0] m_lman, m_rman;

  function automatic logic [MW-1:0] rnd_man();
    logic [MW-1:0] r;
    for (int i = 0; i < MW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_full = '0; m_wp = 0; m_rp = 0; m_valid = 1'b0; m_err = '0;
    m_lexp = '0; m_rexp = '0; m_lman = '0; m_rman = '0;
  endtask

  task automatic drive_idle();
    i_man_left_wr_en = 0; i_man_right_wr_en = 0; i_exp_left_wr_en = 0; i_exp_right_wr_en = 0;
    i_wr_commit = 0; i_rd_en = 0; i_rd_release = 0;
  endtask

  // Advance one clock and apply the sampled inputs to the model.
  task automatic step();
    logic ready, rbv;
    int wp, rp, li, ri;
    @(posedge clk);
    wp = m_wp; rp = m_rp;
    ready = !m_full[wp]; rbv = m_full[rp];
    if (i_man_left_wr_en)  begin if (ready) m_man[0][wp][i_man_left_wr_addr]  = i_man_left_wr_data;  else m_err[0] = 1; end
    if (i_man_right_wr_en) begin if (ready) m_man[1][wp][i_man_right_wr_addr] = i_man_right_wr_data; else m_err[0] = 1; end
    if (i_exp_left_wr_en)  begin if (ready) m_exp[0][wp][i_exp_left_wr_addr]  = i_exp_left_wr_data;  else m_err[0] = 1; end
    if (i_exp_right_wr_en) begin if (ready) m_exp[1][wp][i_exp_right_wr_addr] = i_exp_right_wr_data; else m_err[0] = 1; end
    if (i_wr_commit) begin
      if (ready) begin m_full[wp] = 1; m_wp = 1 - wp; end else m_err[1] = 1;
    end
    m_valid = 1'b0;
    if (i_rd_en) begin
      if (rbv) begin
        m_valid = 1'b1;
        li = int'(i_nv_left_rd_idx) * GR; ri = int'(i_nv_right_rd_idx) * GR;
        for (int g = 0; g < GR; g++) begin
          m_lexp[g*EW +: EW] = m_exp[0][rp][li+g];
          m_rexp[g*EW +: EW] = m_exp[1][rp][ri+g];
          m_lman[g*MW +: MW] = m_man[0][rp][li+g];
          m_rman[g*MW +: MW] = m_man[1][rp][ri+g];
        end
      end else m_err[2] = 1;
    end
    if (i_rd_release) begin
      if (rbv) begin m_full[rp] = 0; m_rp = 1 - rp; end else m_err[2] = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic fill_nvs(input int lo, input int hi);
    for (int nv = lo; nv <= hi; nv++) begin
      for (int g = 0; g < GR; g++) begin
        i_man_left_wr_en = 1; i_man_right_wr_en = 1; i_exp_left_wr_en = 1; i_exp_right_wr_en = 1;
        i_man_left_wr_addr = LAW'(nv*GR+g); i_man_right_wr_addr = LAW'(nv*GR+g);
        i_exp_left_wr_addr = LAW'(nv*GR+g); i_exp_right_wr_addr = LAW'(nv*GR+g);
        i_man_left_wr_data = rnd_man(); i_man_right_wr_data = rnd_man();
        i_exp_left_wr_data = EW'($urandom); i_exp_right_wr_data = EW'($urandom);
        step();
      end
    end
    drive_idle();
  endtask

  task automatic commit();
    i_wr_commit = 1; step(); i_wr_commit = 0;
  endtask

  task automatic release_bank();
    i_rd_release = 1; step(); i_rd_release = 0;
  endtask

  task automatic read_nv(input int li, input int ri);
    i_rd_en = 1; i_nv_left_rd_idx = NIW'(li); i_nv_right_rd_idx = NIW'(ri);
    step();
    i_rd_en = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b exp 1", o_wr_ready); end
    checks++; if (o_rd_bank_valid !== 1'b0) begin errors++; $display("FAIL reset_rbv: got %b exp 0", o_rd_bank_valid); end
    checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b exp 0", o_rd_valid); end
    checks++; if (o_err !== 3'b000) begin errors++; $display("FAIL reset_err: got %b exp 000", o_err); end
    checks++; if (o_nv_left_exp !== '0 || o_nv_right_exp !== '0 || o_nv_left_man !== '0 || o_nv_right_man !== '0) begin
      errors++; $display("FAIL reset_data: got exp_l %h exp_r %h, required zero outputs", o_nv_left_exp, o_nv_right_exp); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int g = 0; g < GR; g++) begin
      i_man_left_wr_en = 1; i_man_right_wr_en = 1; i_exp_left_wr_en = 1; i_exp_right_wr_en = 1;
      i_man_left_wr_addr = LAW'(4+g); i_man_right_wr_addr = LAW'(4+g);
      i_exp_left_wr_addr = LAW'(4+g); i_exp_right_wr_addr = LAW'(4+g);
      i_man_left_wr_data = rnd_man(); i_man_right_wr_data = rnd_man();
      i_exp_left_wr_data = EW'(8'h11 * (g+1)); i_exp_right_wr_data = EW'($urandom);
      step();
    end
    drive_idle();
    commit();
    read_nv(1, 1);
    checks++; if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", o_rd_valid); end
    checks++; if (o_nv_left_exp !== 32'h44332211) begin errors++; $display("FAIL basic_lexp: got %h exp 44332211", o_nv_left_exp); end
    checks++; if (o_nv_left_man !== m_lman) begin errors++; $display("FAIL basic_lman: got %h", o_nv_left_man); $display("  exp %h", m_lman); end
    checks++; if (o_nv_right_man !== m_rman || o_nv_right_exp !== m_rexp) begin
      errors++; $display("FAIL basic_right: got exp %h exp_required %h", o_nv_right_exp, m_rexp); end
    checks++; if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL basic_wr_ready: got %b exp 1", o_wr_ready); end
  endtask

  task automatic test_full_banks();
    do_reset();
    fill_nvs(0, 3); commit();
    fill_nvs(0, 3); commit();
    checks++; if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b exp 0", o_wr_ready); end
    i_man_left_wr_en = 1; i_man_left_wr_addr = '0; i_man_left_wr_data = '1;
    i_exp_left_wr_en = 1; i_exp_left_wr_addr = '0; i_exp_left_wr_data = '1;
    step(); drive_idle();
    checks++; if (o_err !== 3'b001) begin errors++; $display("FAIL full_err: got %b exp 001", o_err); end
    for (int nv = 0; nv < 4; nv++) begin
      read_nv(nv, 3 - nv);
      checks++; if (o_rd_valid !== 1'b1 || o_nv_left_man !== m_lman || o_nv_left_exp !== m_lexp ||
                    o_nv_right_man !== m_rman || o_nv_right_exp !== m_rexp) begin
        errors++; $display("FAIL full_read nv%0d: valid %b lexp %h exp_required %h", nv, o_rd_valid, o_nv_left_exp, m_lexp); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_nvs(0, 2); commit();
    for (int k = 0; k < 3; k++) begin
      i_rd_en = 1; i_nv_left_rd_idx = NIW'(k); i_nv_right_rd_idx = NIW'(2 - k);
      i_rd_release = (k == 2);
      step();
      checks++; if (o_rd_valid !== 1'b1 || o_nv_left_man !== m_lman || o_nv_right_man !== m_rman ||
                    o_nv_left_exp !== m_lexp || o_nv_right_exp !== m_rexp) begin
        errors++; $display("FAIL b2b_read %0d: valid %b lexp %h exp_required %h", k, o_rd_valid, o_nv_left_exp, m_lexp); end
    end
    drive_idle();
    checks++; if (o_rd_bank_valid !== 1'b0 || o_wr_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_release: rbv %b wr_ready %b, required 0 1", o_rd_bank_valid, o_wr_ready); end
    step();
    checks++; if (o_rd_valid !== 1'b0 || o_nv_left_man !== m_lman || o_nv_right_exp !== m_rexp) begin
      errors++; $display("FAIL b2b_hold: valid %b, required 0 with data held", o_rd_valid); end
  endtask

  task automatic test_commit_release();
    do_reset();
    fill_nvs(0, 1); commit();
    fill_nvs(0, 1);
    i_wr_commit = 1; i_rd_release = 1; step(); drive_idle();
    checks++; if (o_wr_ready !== 1'b1 || o_rd_bank_valid !== 1'b1 || o_err !== 3'b000) begin
      errors++; $display("FAIL cr_state: wr_ready %b rbv %b err %b, required 1 1 000", o_wr_ready, o_rd_bank_valid, o_err); end
    read_nv(1, 0);
    checks++; if (o_rd_valid !== 1'b1 || o_nv_left_man !== m_lman || o_nv_right_man !== m_rman ||
                  o_nv_left_exp !== m_lexp || o_nv_right_exp !== m_rexp) begin
      errors++; $display("FAIL cr_read: valid %b lexp %h exp_required %h", o_rd_valid, o_nv_left_exp, m_lexp); end
  endtask

  task automatic test_rd_no_bank();
    do_reset();
    read_nv(0, 0);
    checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL nobank_valid: got %b exp 0", o_rd_valid); end
    checks++; if (o_err !== 3'b100) begin errors++; $display("FAIL nobank_err: got %b exp 100", o_err); end
  endtask

  task automatic test_reset_during_read();
    do_reset();
    fill_nvs(5, 5); commit();
    read_nv(5, 5);
    checks++; if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL rstrd_pre_valid: got %b exp 1", o_rd_valid); end
    rst_n = 0;
    model_reset();
    #1;
    checks++; if (o_rd_valid !== 1'b0 || o_wr_ready !== 1'b1 || o_rd_bank_valid !== 1'b0 ||
                  o_nv_left_exp !== '0 || o_err !== 3'b000) begin
      errors++; $display("FAIL rstrd_async: valid %b wr_ready %b rbv %b lexp %h, required 0 1 0 0", o_rd_valid, o_wr_ready, o_rd_bank_valid, o_nv_left_exp); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    do_reset();
    fill_nvs(0, 7); commit();
    fill_nvs(0, 7); commit();
    release_bank(); release_bank();
    for (int c = 0; c < 400; c++) begin
      i_man_left_wr_en  = ($urandom_range(0, 1) == 1); i_man_left_wr_addr  = LAW'($urandom_range(0, 31));
      i_man_right_wr_en = ($urandom_range(0, 1) == 1); i_man_right_wr_addr = LAW'($urandom_range(0, 31));
      i_exp_left_wr_en  = ($urandom_range(0, 1) == 1); i_exp_left_wr_addr  = LAW'($urandom_range(0, 31));
      i_exp_right_wr_en = ($urandom_range(0, 1) == 1); i_exp_right_wr_addr = LAW'($urandom_range(0, 31));
      i_man_left_wr_data = rnd_man(); i_man_right_wr_data = rnd_man();
      i_exp_left_wr_data = EW'($urandom); i_exp_right_wr_data = EW'($urandom);
      i_wr_commit  = ($urandom_range(0, 7) == 0);
      i_rd_release = ($urandom_range(0, 7) == 0);
      i_rd_en      = ($urandom_range(0, 1) == 1);
      i_nv_left_rd_idx = NIW'($urandom_range(0, 7)); i_nv_right_rd_idx = NIW'($urandom_range(0, 7));
      step();
      checks++; if (o_rd_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c%0d: got %b exp %b", c, o_rd_valid, m_valid); end
      checks++; if (o_wr_ready !== !m_full[m_wp]) begin errors++; $display("FAIL rnd_wr_ready c%0d: got %b exp %b", c, o_wr_ready, !m_full[m_wp]); end
      checks++; if (o_rd_bank_valid !== m_full[m_rp]) begin errors++; $display("FAIL rnd_rbv c%0d: got %b exp %b", c, o_rd_bank_valid, m_full[m_rp]); end
      checks++; if (o_err !== m_err) begin errors++; $display("FAIL rnd_err c%0d: got %b exp %b", c, o_err, m_err); end
      checks++; if (o_nv_left_exp !== m_lexp || o_nv_right_exp !== m_rexp) begin
        errors++; $display("FAIL rnd_exp c%0d: got %h/%h exp %h/%h", c, o_nv_left_exp, o_nv_right_exp, m_lexp, m_rexp); end
      checks++; if (o_nv_left_man !== m_lman) begin errors++; $display("FAIL rnd_lman c%0d: left mantissa differs from model", c); end
      checks++; if (o_nv_right_man !== m_rman) begin errors++; $display("FAIL rnd_rman c%0d: right mantissa differs from model", c); end
    end
    drive_idle();
  endtask

  initial begin
    rst_n = 1'b1;
    drive_idle();
    i_man_left_wr_addr = '0; i_man_right_wr_addr = '0; i_exp_left_wr_addr = '0; i_exp_right_wr_addr = '0;
    i_man_left_wr_data = '0; i_man_right_wr_data = '0; i_exp_left_wr_data = '0; i_exp_right_wr_data = '0;
    i_nv_left_rd_idx = '0; i_nv_right_rd_idx = '0;
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < ND*GR; a++) begin m_man[s][b][a] = '0; m_exp[s][b][a] = '0; end
    model_reset();
    test_reset();
    test_basic();
    test_full_banks();
    test_back_to_back();
    test_commit_release();
    test_rd_no_bank();
    test_reset_during_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
